bayer_window2x2: RTL
====================

# bayer_window2x2

Parametrised 2x2 sliding-window engine for the camera pixel path. It accepts a raster stream of single-channel Bayer (RGGB) samples and keeps its own one-row line buffer. For every complete 2x2 window it produces the window mean (grey) and a demosaiced R/G/B triple. An optional 2x decimation mode emits only non-overlapping Bayer cells, for feeding a half-resolution RGB path.

## Interface
Parameters:
- DATA_WIDTH, 12, sample and output channel width
- ROW_LENGTH, 1280, samples per row; line-buffer depth; must be ≥2

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_valid  in  1  sample strobe; i_data/i_sof consumed only when high
- i_sof  in  1  start of frame; marks the current sample as pixel (0,0)
- i_data  in  DATA_WIDTH  raw Bayer sample, raster order
- i_decimate  in  1  1 = emit odd-row/odd-col windows only; sampled on SOF sample
- o_valid  out  1  output strobe, one cycle per emitted window
- o_gray  out  DATA_WIDTH  floor mean of 4 window samples
- o_r, o_g, o_b  out  DATA_WIDTH each  demosaiced channels

## Operation
- Accepted sample = cycle with i_valid=1. With i_valid=0, all state holds (counters, line buffer, window regs).
- Position counters col (0..ROW_LENGTH-1) and row. On each accepted sample: col increments; at ROW_LENGTH-1 it wraps to 0 and row increments. row saturates at all-ones; only its LSB and the flag row≥1 are used.
- Accepted sample with i_sof=1: that sample is (0,0). Counters are forced accordingly, and the decimate mode is latched from i_decimate. i_sof with i_valid=0 is ignored.
- Line buffer: circular, ROW_LENGTH×DATA_WIDTH, addressed by col. On an accepted sample at (r,c), entry c is read as the (r-1,c) sample, then overwritten with i_data in the same cycle (read-before-write).
- Window for current sample at (r,c): P00=(r,c)=i_data, P01=(r,c-1), P10=(r-1,c), P11=(r-1,c-1). P01 and P11 are registers loaded only on accepted samples.
- Window complete iff r≥1 and c≥1. Before the first SOF after reset, the stream is treated as starting at (0,0).
- Emit when the window is complete and either decimate=0 or (r odd and c odd).
- RGGB phase: (even,even)=R, (even,odd)=G, (odd,even)=G, (odd,odd)=B. Each window holds exactly one R, one B and two G; they are selected by the parities of r and c.
- Arithmetic:
  - gray = (P00+P01+P10+P11) >> 2, with the sum computed at DATA_WIDTH+2 bits.
  - g = (Ga+Gb) >> 1, with the sum computed at DATA_WIDTH+1 bits.
  - r and b pass through unchanged.
  - All results truncate; none overflow.
- Line-buffer contents are not cleared by reset or SOF. Row 0 never emits, so stale data is never visible.

## Timing
- Latency 1: outputs are registered and appear the cycle after the accepted sample that completes the window.
- o_valid is high for exactly one cycle per emitted window. It is low in any cycle following a non-accepted or non-emitting sample.
- o_gray/o_r/o_g/o_b update only when o_valid rises and hold otherwise.
- Reset (asynchronous):
  - All outputs are 0 immediately.
  - col=0, row=0, decimate=0, P01=P11=0.
  - Reset mid-frame is legal. The first post-reset sample is treated as (0,0).
- SOF mid-row: the counters restart on that sample. No output is emitted for the new frame until its (1,1).
- Throughput: one sample per cycle sustained. There is no backpressure.

## Test plan
Bench parameters: ROW_LENGTH=4, DATA_WIDTH=12. Unless noted, the stimulus is a 4×4 frame with value = 4·row+col and i_sof on the first sample.

1. Decimate=0, back-to-back:
   - Exactly 9 o_valid pulses.
   - First pulse, window (1,1): gray=2, r=0, g=2, b=5.
   - Second pulse, window (1,2): gray=3, r=2, g=3, b=5.
2. Decimate=1, same frame:
   - Exactly 4 pulses, at (1,1), (1,3), (3,1), (3,3).
   - At (3,3): gray=12, r=10, g=12, b=15.
3. Same frame with i_valid deasserted on random cycles (≥30% idle): the output sequence is identical to scenario 1, and each pulse comes 1 cycle after its completing sample.
4. Constant 4095 frame: all emitted gray/r/g/b = 4095 (no overflow).
5. SOF reasserted at (2,2) of frame 1, followed by a new 4×4 frame: no o_valid until the new frame's (1,1), which yields gray=2, r=0, g=2, b=5. Decimate is relatched at the new SOF.
6. i_rst_n pulsed low at (2,1) mid-frame:
   - o_valid and all outputs go to 0 asynchronously.
   - After release, a fresh frame without i_sof behaves exactly as scenario 1.

Source files
------------

// File: rtl/bayer_window2x2.sv
// 2x2 sliding-window engine over a raster RGGB Bayer stream: per complete window it emits the
// floor mean and a demosaiced R/G/B triple, optionally only on non-overlapping cells.
module bayer_window2x2 #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ROW_LENGTH = 1280
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic                  i_sof,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_decimate,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_gray,
  output logic [DATA_WIDTH-1:0] o_r,
  output logic [DATA_WIDTH-1:0] o_g,
  output logic [DATA_WIDTH-1:0] o_b
);

  localparam int unsigned COL_W = $clog2(ROW_LENGTH);
  localparam int unsigned ROW_W = 16;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LENGTH - 1);

  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic                  r_dec;
  logic [DATA_WIDTH-1:0] r_p01;
  logic [DATA_WIDTH-1:0] r_p11;
  logic [DATA_WIDTH-1:0] r_line [ROW_LENGTH];
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_gray, r_r, r_g, r_b;

  logic [COL_W-1:0]      w_col, w_col_nxt;
  logic [ROW_W-1:0]      w_row, w_row_nxt;
  logic                  w_dec;
  logic [DATA_WIDTH-1:0] w_p10;
  logic                  w_emit;
  logic [DATA_WIDTH+1:0] w_sum4;
  logic [DATA_WIDTH:0]   w_gsum;
  logic [DATA_WIDTH-1:0] w_red, w_blue, w_ga, w_gb;

  // An accepted SOF sample is (0,0) regardless of where the counters were.
  assign w_col = i_sof ? '0 : r_col;
  assign w_row = i_sof ? '0 : r_row;
  assign w_dec = i_sof ? i_decimate : r_dec;
  assign w_p10 = r_line[w_col];

  assign w_emit = i_valid && (w_row != '0) && (w_col != '0) &&
                  (!w_dec || (w_row[0] && w_col[0]));

  always_comb begin
    w_col_nxt = w_col + COL_W'(1);
    w_row_nxt = w_row;
    if (w_col == COL_LAST) begin
      w_col_nxt = '0;
      w_row_nxt = (&w_row) ? w_row : w_row + ROW_W'(1);
    end
  end

  // Phase of the current sample decides which window position holds R and which holds B.
  always_comb begin
    w_red  = i_data;
    w_blue = r_p11;
    w_ga   = r_p01;
    w_gb   = w_p10;
    unique case ({w_row[0], w_col[0]})
      2'b00: begin w_red = i_data; w_blue = r_p11;  w_ga = r_p01;  w_gb = w_p10; end
      2'b01: begin w_red = r_p01;  w_blue = w_p10;  w_ga = i_data; w_gb = r_p11; end
      2'b10: begin w_red = w_p10;  w_blue = r_p01;  w_ga = i_data; w_gb = r_p11; end
      2'b11: begin w_red = r_p11;  w_blue = i_data; w_ga = r_p01;  w_gb = w_p10; end
      default: ;
    endcase
  end

  assign w_sum4 = (DATA_WIDTH+2)'(i_data) + (DATA_WIDTH+2)'(r_p01) +
                  (DATA_WIDTH+2)'(w_p10) + (DATA_WIDTH+2)'(r_p11);
  assign w_gsum = (DATA_WIDTH+1)'(w_ga) + (DATA_WIDTH+1)'(w_gb);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_dec   <= 1'b0;
      r_p01   <= '0;
      r_p11   <= '0;
      r_valid <= 1'b0;
      r_gray  <= '0;
      r_r     <= '0;
      r_g     <= '0;
      r_b     <= '0;
    end else begin
      r_valid <= w_emit;
      if (i_valid) begin
        r_col <= w_col_nxt;
        r_row <= w_row_nxt;
        r_dec <= w_dec;
        r_p01 <= i_data;
        r_p11 <= w_p10;
      end
      if (w_emit) begin
        r_gray <= DATA_WIDTH'(w_sum4 >> 2);
        r_r    <= w_red;
        r_g    <= DATA_WIDTH'(w_gsum >> 1);
        r_b    <= w_blue;
      end
    end
  end

  // Read-before-write: w_p10 above sees the previous row's sample in this column.
  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      r_line[w_col] <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_gray  = r_gray;
  assign o_r     = r_r;
  assign o_g     = r_g;
  assign o_b     = r_b;

endmodule
